// File: rtl/intra_ref_fetch_ctrl_pkg.sv
// Shared definitions for the intra reference fetch controllers:
// FSM states, beat tags, substitution value and burst lengths.
package intra_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE_TOP,
        ISSUE_LEFT,
        DRAIN,
        FIN
    } fetch_state_e;

    // Travels with each beat until its read data returns.
    typedef struct packed {
        logic valid;
        logic left;
        logic subst;
    } beat_tag_t;

    localparam logic [7:0]  REF_SUBST_VAL = 8'd128;
    localparam int unsigned TOP_BEATS     = 9;
    localparam int unsigned LEFT_BEATS    = 8;

endpackage

// File: rtl/intra_ref_fetch_ctrl_if.sv
// Control, frame-memory and reference-buffer signals of the fetch controller.
// The slave modport is the controller's view; master is the surrounding logic.
interface intra_ref_fetch_ctrl_if #(
    parameter int unsigned AW = 17
);
    logic          START;
    logic [5:0]    BLK_X;
    logic [4:0]    BLK_Y;
    logic          MEM_RD_EN;
    logic [AW-1:0] MEM_ADDR;
    logic [7:0]    MEM_RDATA;
    logic [7:0]    REF_DATA;
    logic          PRESET;
    logic          EN_TOP;
    logic          EN_LEFT;
    logic          TOP_AVAIL;
    logic          LEFT_AVAIL;
    logic          BUSY;
    logic          DONE;

    modport slave (
        input  START, BLK_X, BLK_Y, MEM_RDATA,
        output MEM_RD_EN, MEM_ADDR, REF_DATA, PRESET, EN_TOP, EN_LEFT,
               TOP_AVAIL, LEFT_AVAIL, BUSY, DONE
    );

    modport master (
        output START, BLK_X, BLK_Y, MEM_RDATA,
        input  MEM_RD_EN, MEM_ADDR, REF_DATA, PRESET, EN_TOP, EN_LEFT,
               TOP_AVAIL, LEFT_AVAIL, BUSY, DONE
    );
endinterface

// File: rtl/intra_ref_fetch_ctrl_ref_beat_delay.sv
// Delays a beat tag by DEPTH cycles so it lines up with the memory read data.
module ref_beat_delay
    import intra_pkg::*;
#(
    parameter int unsigned DEPTH = 1
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  beat_tag_t tag_i,
    output beat_tag_t tag_o
);
    beat_tag_t stage_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= tag_i;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign tag_o = stage_q[DEPTH-1];
endmodule

// File: rtl/intra_ref_fetch_ctrl.sv
// Fetches the 9 top (corner first) and 8 left reference pixels of one 8x8
// block, substituting 128 for unavailable neighbours with unchanged timing.
module intra_ref_fetch_ctrl
    import intra_pkg::*;
#(
    parameter int unsigned BLK_COLS = 40,
    parameter int unsigned BLK_ROWS = 30,
    parameter int unsigned AW       = 17,
    parameter int unsigned RD_LAT   = 1
) (
    input logic                   CLK,
    input logic                   RST,
    intra_ref_fetch_ctrl_if.slave bus
);
    localparam logic [AW-1:0] ROW_STRIDE = AW'(BLK_COLS * 8);
    localparam logic [AW-1:0] LEFT_STEP  = AW'(BLK_COLS * 8 - 8);

    fetch_state_e  state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          top_avail_q, top_avail_d;
    logic          left_avail_q, left_avail_d;
    beat_tag_t     tag_issue, tag_out;
    logic          in_range, accept, rd_en, done;
    logic [AW-1:0] row_base, corner_addr;

    assign in_range = (32'(bus.BLK_X) < BLK_COLS) && (32'(bus.BLK_Y) < BLK_ROWS);
    assign accept   = bus.START && (state_q == IDLE) && in_range && !RST;

    // Only multiply, by a constant, once per block; beats then walk by add.
    assign row_base    = AW'(32'(bus.BLK_Y) * (64 * BLK_COLS));
    assign corner_addr = row_base - ROW_STRIDE + AW'({bus.BLK_X, 3'b000}) - AW'(1);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        top_avail_d  = top_avail_q;
        left_avail_d = left_avail_q;
        tag_issue    = '0;
        rd_en        = 1'b0;
        done         = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d      = ISSUE_TOP;
                    cnt_d        = '0;
                    addr_d       = corner_addr;
                    top_avail_d  = (bus.BLK_Y != '0);
                    left_avail_d = (bus.BLK_X != '0);
                end
            end
            ISSUE_TOP: begin
                tag_issue.valid = 1'b1;
                tag_issue.subst = (cnt_q == '0) ? !(top_avail_q && left_avail_q)
                                                : !top_avail_q;
                rd_en  = !tag_issue.subst;
                cnt_d  = cnt_q + 4'd1;
                addr_d = addr_q + AW'(1);
                if (cnt_q == 4'(TOP_BEATS - 1)) begin
                    // Last top pixel -> left column, first row of the block.
                    state_d = ISSUE_LEFT;
                    cnt_d   = '0;
                    addr_d  = addr_q + LEFT_STEP;
                end
            end
            ISSUE_LEFT: begin
                tag_issue.valid = 1'b1;
                tag_issue.left  = 1'b1;
                tag_issue.subst = !left_avail_q;
                rd_en  = !tag_issue.subst;
                cnt_d  = cnt_q + 4'd1;
                addr_d = addr_q + ROW_STRIDE;
                if (cnt_q == 4'(LEFT_BEATS - 1)) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end
            end
            DRAIN: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'(RD_LAT - 1)) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            top_avail_q  <= 1'b0;
            left_avail_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            top_avail_q  <= top_avail_d;
            left_avail_q <= left_avail_d;
        end
    end

    ref_beat_delay #(.DEPTH(RD_LAT)) u_delay (
        .clk_i (CLK),
        .rst_i (RST),
        .tag_i (tag_issue),
        .tag_o (tag_out)
    );

    assign bus.MEM_RD_EN  = rd_en;
    assign bus.MEM_ADDR   = rd_en ? addr_q : '0;
    assign bus.PRESET     = accept;
    assign bus.BUSY       = (state_q != IDLE);
    assign bus.DONE       = done;
    assign bus.TOP_AVAIL  = top_avail_q;
    assign bus.LEFT_AVAIL = left_avail_q;
    assign bus.EN_TOP     = tag_out.valid && !tag_out.left;
    assign bus.EN_LEFT    = tag_out.valid && tag_out.left;
    assign bus.REF_DATA   = !tag_out.valid ? 8'd0
                          : tag_out.subst  ? REF_SUBST_VAL
                          :                  bus.MEM_RDATA;
endmodule

// File: tb/tb_intra_ref_fetch_ctrl.sv
// Drives two controllers (read latency 1 and 3) with the same stimulus and
// checks every cycle against a per-block schedule derived from pixel coordinates.
module tb_intra_ref_fetch_ctrl;
    localparam int COLS = 40;
    localparam int ROWS = 30;
    localparam int W    = COLS * 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    intra_ref_fetch_ctrl_if #(.AW(17)) b1();
    intra_ref_fetch_ctrl_if #(.AW(17)) b3();

    intra_ref_fetch_ctrl #(.BLK_COLS(40), .BLK_ROWS(30), .AW(17), .RD_LAT(1)) dut1 (
        .CLK (clk), .RST (rst), .bus (b1.slave));
    intra_ref_fetch_ctrl #(.BLK_COLS(40), .BLK_ROWS(30), .AW(17), .RD_LAT(3)) dut3 (
        .CLK (clk), .RST (rst), .bus (b3.slave));

    function automatic logic [7:0] mem_f(input logic [16:0] a);
        return a[7:0] ^ {a[14:8], 1'b1} ^ 8'h3C;
    endfunction

    // Frame memory: returns mem_f(addr) RD_LAT cycles after a read.
    logic [16:0] ah1 [4], ah3 [4];
    logic        eh1 [4], eh3 [4];
    always @(posedge clk) begin
        ah1[0] <= b1.MEM_ADDR; eh1[0] <= b1.MEM_RD_EN;
        ah3[0] <= b3.MEM_ADDR; eh3[0] <= b3.MEM_RD_EN;
        for (int i = 1; i < 4; i++) begin
            ah1[i] <= ah1[i-1]; eh1[i] <= eh1[i-1];
            ah3[i] <= ah3[i-1]; eh3[i] <= eh3[i-1];
        end
    end
    assign b1.MEM_RDATA = (eh1[0] === 1'b1) ? mem_f(ah1[0]) : 8'hEE;
    assign b3.MEM_RDATA = (eh3[2] === 1'b1) ? mem_f(ah3[2]) : 8'hEE;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit check_en = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    // Beat b: 0 corner, 1..8 top row, 9..16 left column.
    function automatic int beat_addr(input int b, input int x, input int y);
        if (b == 0) return (y*8 - 1) * W + x*8 - 1;
        if (b < 9)  return (y*8 - 1) * W + x*8 + b - 1;
        return (y*8 + b - 9) * W + x*8 - 1;
    endfunction

    function automatic bit beat_subst(input int b, input int x, input int y);
        if (b == 0) return !(x != 0 && y != 0);
        if (b < 9)  return (y == 0);
        return (x == 0);
    endfunction

    bit m_act [2];
    int m_t   [2];
    int m_x   [2];
    int m_y   [2];
    bit m_tav [2];
    bit m_lav [2];
    bit prev_rst = 1'b1;

    task automatic model_check(input int d, input bit st, input int x, input int y, input bit r);
        int    lat, t, b, e;
        bit    busy_e, acc, rd_e, out_v, done_e;
        logic [31:0] ref_e;
        logic        o_pre, o_busy, o_done, o_rd, o_et, o_el, o_ta, o_la;
        logic [16:0] o_addr;
        logic [7:0]  o_ref;
        string       p;
        lat = (d == 0) ? 1 : 3;
        p   = (d == 0) ? "L1" : "L3";
        if (d == 0) begin
            o_pre = b1.PRESET; o_busy = b1.BUSY; o_done = b1.DONE; o_rd = b1.MEM_RD_EN;
            o_et = b1.EN_TOP; o_el = b1.EN_LEFT; o_ta = b1.TOP_AVAIL; o_la = b1.LEFT_AVAIL;
            o_addr = b1.MEM_ADDR; o_ref = b1.REF_DATA;
        end else begin
            o_pre = b3.PRESET; o_busy = b3.BUSY; o_done = b3.DONE; o_rd = b3.MEM_RD_EN;
            o_et = b3.EN_TOP; o_el = b3.EN_LEFT; o_ta = b3.TOP_AVAIL; o_la = b3.LEFT_AVAIL;
            o_addr = b3.MEM_ADDR; o_ref = b3.REF_DATA;
        end
        busy_e = m_act[d] && m_t[d] >= 1 && m_t[d] <= 18 + lat;
        acc    = st && !r && !busy_e && x < COLS && y < ROWS;
        if (acc) begin
            m_act[d] = 1'b1; m_t[d] = 0; m_x[d] = x; m_y[d] = y;
        end
        t      = m_act[d] ? m_t[d] : -100;
        b      = t - 1;
        e      = t - 1 - lat;
        rd_e   = (b >= 0 && b <= 16) && !beat_subst(b, m_x[d], m_y[d]);
        out_v  = (e >= 0 && e <= 16);
        done_e = (t == 18 + lat);
        ref_e  = !out_v ? 32'd0
               : beat_subst(e, m_x[d], m_y[d]) ? 32'd128
               : 32'(mem_f(17'(beat_addr(e, m_x[d], m_y[d]))));
        if (check_en) begin
            chk({p, "_preset"}, 32'(o_pre), 32'(acc));
            chk({p, "_busy"}, 32'(o_busy), 32'(busy_e));
            chk({p, "_done"}, 32'(o_done), 32'(done_e));
            chk({p, "_rd_en"}, 32'(o_rd), 32'(rd_e));
            if (rd_e) chk({p, "_addr"}, 32'(o_addr), 32'(beat_addr(b, m_x[d], m_y[d])));
            if (prev_rst) chk({p, "_addr_rst"}, 32'(o_addr), 32'd0);
            chk({p, "_en_top"}, 32'(o_et), 32'(out_v && e < 9));
            chk({p, "_en_left"}, 32'(o_el), 32'(out_v && e >= 9));
            chk({p, "_ref_data"}, 32'(o_ref), ref_e);
            chk({p, "_top_avail"}, 32'(o_ta), 32'(m_tav[d]));
            chk({p, "_left_avail"}, 32'(o_la), 32'(m_lav[d]));
        end
        if (r) begin
            m_act[d] = 1'b0; m_tav[d] = 1'b0; m_lav[d] = 1'b0;
        end else begin
            if (acc) begin
                m_tav[d] = (y != 0); m_lav[d] = (x != 0);
            end
            if (m_act[d]) begin
                m_t[d]++;
                if (m_t[d] > 18 + lat) m_act[d] = 1'b0;
            end
        end
    endtask

    task automatic do_cycle(input bit st, input int x, input int y, input bit r);
        @(posedge clk);
        #1;
        rst = r;
        b1.START = st; b1.BLK_X = 6'(x); b1.BLK_Y = 5'(y);
        b3.START = st; b3.BLK_X = 6'(x); b3.BLK_Y = 5'(y);
        @(negedge clk);
        cyc++;
        model_check(0, st, x, y, r);
        model_check(1, st, x, y, r);
        prev_rst = r;
    endtask

    task automatic idle(input int n);
        repeat (n) do_cycle(1'b0, 0, 0, 1'b0);
    endtask

    initial begin
        b1.START = 1'b0; b1.BLK_X = '0; b1.BLK_Y = '0;
        b3.START = 1'b0; b3.BLK_X = '0; b3.BLK_Y = '0;
        repeat (3) do_cycle(1'b0, 0, 0, 1'b1);
        check_en = 1'b1;
        idle(2);
        // Interior block
        do_cycle(1'b1, 3, 2, 1'b0);
        idle(24);
        // Picture corner: everything substituted
        do_cycle(1'b1, 0, 0, 1'b0);
        idle(24);
        // Left edge, extra STARTs while busy and in/around the DONE cycle
        do_cycle(1'b1, 0, 5, 1'b0);
        idle(4);
        do_cycle(1'b1, 1, 1, 1'b0);
        idle(13);
        do_cycle(1'b1, 2, 2, 1'b0);
        idle(1);
        do_cycle(1'b1, 4, 4, 1'b0);
        idle(24);
        // Reset at cycle 6 of a fetch, then a clean fetch
        do_cycle(1'b1, 5, 4, 1'b0);
        idle(5);
        do_cycle(1'b0, 0, 0, 1'b1);
        idle(2);
        do_cycle(1'b1, 7, 3, 1'b0);
        idle(24);
        // Bottom-right block and out-of-range requests
        do_cycle(1'b1, 39, 29, 1'b0);
        idle(24);
        do_cycle(1'b1, 40, 1, 1'b0);
        idle(2);
        do_cycle(1'b1, 2, 30, 1'b0);
        idle(2);
        // Random traffic
        for (int i = 0; i < 600; i++) begin
            do_cycle($urandom_range(0, 3) == 0, int'($urandom_range(0, 45)),
                     int'($urandom_range(0, 31)), $urandom_range(0, 199) == 0);
        end
        idle(25);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
